// File: rtl/motor_cmd_sched.sv
// Motor command sequencer: Bluetooth command decode, bumper debounce, automatic back-off and hold.
// Optional link watchdog enabled by defining CMD_WDT_EN.
module motor_cmd_sched #(
  parameter int unsigned DEB_CYCLES     = 12000,
  parameter int unsigned BACKOFF_CYCLES = 6000000,
  parameter logic [4:0]  BACKOFF_SPD    = 5'd12,
  parameter int unsigned WDT_CYCLES     = 12000000
) (
  input  logic       WF_CLK,
  input  logic       WF_BUTTON,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [5:0] bump_n,
  output logic       motorL_en,
  output logic       motorL_dir,
  output logic [4:0] motorL_spd,
  output logic       motorR_en,
  output logic       motorR_dir,
  output logic [4:0] motorR_spd,
  output logic [1:0] state,
  output logic       cmd_drop
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int unsigned BO_W  = $clog2(BACKOFF_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_DRIVE   = 2'b01,
    S_BACKOFF = 2'b10,
    S_HOLD    = 2'b11
  } state_t;

  typedef struct packed {
    logic       en;
    logic       dir;
    logic [4:0] spd;
  } side_t;

  localparam side_t SIDE_OFF     = '{en: 1'b0, dir: 1'b0, spd: 5'd0};
  localparam side_t SIDE_BACKOFF = '{en: 1'b1, dir: 1'b1, spd: BACKOFF_SPD};

  state_t              r_state;
  side_t               r_left;
  side_t               r_right;
  logic                r_cmd_drop;
  logic [BO_W-1:0]     r_bo_cnt;
  logic [5:0]          r_sync1;
  logic [5:0]          r_sync2;
  logic [DEB_W-1:0]    r_deb_cnt;
  logic                r_deb_level;

  logic                w_bump_any;
  logic                w_deb_chg;
  logic                w_deb_done;
  logic                w_bump_evt;
  logic                w_cmd;
  logic                w_side;
  logic                w_dir;
  side_t               w_cmd_val;
  logic                w_wdt_exp;

  // Two-flop synchronizer; released (all ones) out of reset
  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= bump_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_bump_any = ~&r_sync2;
  assign w_deb_chg  = (w_bump_any != r_deb_level);
  assign w_deb_done = (r_deb_cnt == DEB_W'(DEB_CYCLES - 1));
  // Event fires on the same edge the debounced level flips to pressed
  assign w_bump_evt = w_deb_chg & w_deb_done & w_bump_any;

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      r_deb_cnt   <= '0;
      r_deb_level <= 1'b0;
    end else if (!w_deb_chg) begin
      r_deb_cnt <= '0;
    end else if (w_deb_done) begin
      r_deb_cnt   <= '0;
      r_deb_level <= w_bump_any;
    end else begin
      r_deb_cnt <= r_deb_cnt + DEB_W'(1);
    end
  end

  assign w_cmd     = rx_valid & rx_data[7];
  assign w_side    = rx_data[6];
  assign w_dir     = rx_data[5];
  assign w_cmd_val = '{en: 1'b1, dir: rx_data[5], spd: rx_data[4:0]};

`ifdef CMD_WDT_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] r_wdt_cnt;

  assign w_wdt_exp = (r_state == S_DRIVE) && (r_wdt_cnt == WDT_W'(WDT_CYCLES - 1));

  // Runs only while driving; any valid command restarts the timeout window
  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      r_wdt_cnt <= '0;
    end else if ((r_state != S_DRIVE) || w_cmd || w_wdt_exp) begin
      r_wdt_cnt <= '0;
    end else begin
      r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
    end
  end
`else
  assign w_wdt_exp = 1'b0;
`endif

  // Sequencer with registered motor outputs
  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      r_state    <= S_IDLE;
      r_left     <= SIDE_OFF;
      r_right    <= SIDE_OFF;
      r_cmd_drop <= 1'b0;
      r_bo_cnt   <= '0;
    end else begin
      r_cmd_drop <= 1'b0;
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_cmd) begin
            // Forward moves into a still-pressed bumper are refused
            if (r_deb_level && !w_dir) begin
              r_cmd_drop <= 1'b1;
            end else begin
              r_state <= S_DRIVE;
              if (w_side) r_right <= w_cmd_val;
              else        r_left  <= w_cmd_val;
            end
          end
        end
        S_DRIVE: begin
          if (w_bump_evt) begin
            r_state    <= S_BACKOFF;
            r_bo_cnt   <= BO_W'(BACKOFF_CYCLES - 1);
            r_left     <= SIDE_BACKOFF;
            r_right    <= SIDE_BACKOFF;
            r_cmd_drop <= w_cmd;
          end else if (w_cmd) begin
            if (w_side) r_right <= w_cmd_val;
            else        r_left  <= w_cmd_val;
          end else if (w_wdt_exp) begin
            r_state <= S_IDLE;
            r_left  <= SIDE_OFF;
            r_right <= SIDE_OFF;
          end
        end
        S_BACKOFF: begin
          r_cmd_drop <= w_cmd;
          if (r_bo_cnt == '0) begin
            r_state <= S_HOLD;
            r_left  <= SIDE_OFF;
            r_right <= SIDE_OFF;
          end else begin
            r_bo_cnt <= r_bo_cnt - BO_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_left  <= SIDE_OFF;
          r_right <= SIDE_OFF;
        end
      endcase
    end
  end

  assign motorL_en  = r_left.en;
  assign motorL_dir = r_left.dir;
  assign motorL_spd = r_left.spd;
  assign motorR_en  = r_right.en;
  assign motorR_dir = r_right.dir;
  assign motorR_spd = r_right.spd;
  assign state      = r_state;
  assign cmd_drop   = r_cmd_drop;

endmodule

// File: tb/tb_motor_cmd_sched.sv
// Directed bench for motor_cmd_sched: commands, bump back-off/hold, watchdog (when CMD_WDT_EN), async reset.
module tb_motor_cmd_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [5:0] bump_n;
  logic       motorL_en, motorL_dir, motorR_en, motorR_dir;
  logic [4:0] motorL_spd, motorR_spd;
  logic [1:0] state;
  logic       cmd_drop;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  motor_cmd_sched #(
    .DEB_CYCLES     (4),
    .BACKOFF_CYCLES (20),
    .BACKOFF_SPD    (5'd12),
    .WDT_CYCLES     (50)
  ) u_dut (
    .WF_CLK     (clk),
    .WF_BUTTON  (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .bump_n     (bump_n),
    .motorL_en  (motorL_en),
    .motorL_dir (motorL_dir),
    .motorL_spd (motorL_spd),
    .motorR_en  (motorR_en),
    .motorR_dir (motorR_dir),
    .motorR_spd (motorR_spd),
    .state      (state),
    .cmd_drop   (cmd_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Side outputs packed as {en, dir, spd}
  task automatic check_lr(input string tag, input logic [6:0] l_exp, input logic [6:0] r_exp);
    check({tag, "_L"}, 32'({motorL_en, motorL_dir, motorL_spd}), 32'(l_exp));
    check({tag, "_R"}, 32'({motorR_en, motorR_dir, motorR_spd}), 32'(r_exp));
  endtask

  // Called at a negedge; returns at the next negedge with the result visible
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got expired expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    bump_n   = 6'h3F;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_drop", 32'(cmd_drop), 32'd0);
    check_lr("rst", 7'h00, 7'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send(8'h95);
    check("c95_state", 32'(state), 32'd1);
    check_lr("c95", 7'b1_0_10101, 7'h00);
    send(8'hE3);
    check_lr("cE3", 7'b1_0_10101, 7'b1_1_00011);

    // Bump: 2 sync + 4 stable cycles
    bump_n[2] = 1'b0;
    k = 0;
    while (state != 2'b10 && k < 30) begin @(negedge clk); k++; end
    check("bump_lat", 32'(k), 32'd6);
    check_lr("bo_drv", 7'b1_1_01100, 7'b1_1_01100);
    k = 0;
    while (state != 2'b11 && k < 40) begin @(negedge clk); k++; end
    check("bo_len", 32'(k), 32'd20);
    check_lr("hold", 7'h00, 7'h00);

    send(8'h85);
    check("h85_drop", 32'(cmd_drop), 32'd1);
    check("h85_state", 32'(state), 32'd3);
    check_lr("h85", 7'h00, 7'h00);
    @(negedge clk);
    check("h85_pulse", 32'(cmd_drop), 32'd0);
    send(8'hA5);
    check("hA5_state", 32'(state), 32'd1);
    check("hA5_drop", 32'(cmd_drop), 32'd0);
    check_lr("hA5", 7'b1_1_00101, 7'h00);

    bump_n = 6'h3F;
    repeat (10) @(negedge clk);
    send(8'h81);
    check_lr("c81", 7'b1_0_00001, 7'h00);
`ifdef CMD_WDT_EN
    repeat (49) @(negedge clk);
    check("wdt_pre", 32'(state), 32'd1);
    @(negedge clk);
    check("wdt_exp", 32'(state), 32'd0);
    check_lr("wdt_exp", 7'h00, 7'h00);
    send(8'h81);
    repeat (49) @(negedge clk);
    send(8'h9F);
    check("wdt_race", 32'(state), 32'd1);
    check_lr("wdt_race", 7'b1_0_11111, 7'h00);
    repeat (49) @(negedge clk);
    check("wdt_reload", 32'(state), 32'd1);
    @(negedge clk);
    check("wdt_exp2", 32'(state), 32'd0);
`else
    repeat (80) @(negedge clk);
    check("no_wdt", 32'(state), 32'd1);
    check_lr("no_wdt", 7'b1_0_00001, 7'h00);
`endif

    // Command on the bump-event cycle loses to the bump
    send(8'h81);
    bump_n[0] = 1'b0;
    repeat (5) @(negedge clk);
    send(8'hC7);
    check("race_state", 32'(state), 32'd2);
    check("race_drop", 32'(cmd_drop), 32'd1);
    check_lr("race", 7'b1_1_01100, 7'b1_1_01100);
    repeat (3) @(negedge clk);
    check("pre_rst", 32'(state), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check_lr("arst", 7'h00, 7'h00);
    bump_n = 6'h3F;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send(8'h15);
    check("b15_state", 32'(state), 32'd0);
    check("b15_drop", 32'(cmd_drop), 32'd0);
    check_lr("b15", 7'h00, 7'h00);

    // IDLE with bumper pressed: forward refused, reverse allowed
    bump_n[5] = 1'b0;
    repeat (8) @(negedge clk);
    send(8'h85);
    check("i85_drop", 32'(cmd_drop), 32'd1);
    check("i85_state", 32'(state), 32'd0);
    send(8'hA5);
    check("iA5_state", 32'(state), 32'd1);
    check_lr("iA5", 7'b1_1_00101, 7'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
